// File: rtl/apb_cmd_master_if.sv
// Bundle of the command stream, response stream and APB3 bus seen by apb_cmd_master.
//   master modport : initiator view (accepts commands, returns responses, drives APB requests)
//   slave  modport : environment view (command source, response sink, APB slave)
//   CMD_VALID/CMD_READY/CMD_WRITE/CMD_ADDR/CMD_WDATA : command stream
//   RSP_VALID/RSP_READY/RSP_RDATA/RSP_ERR/RSP_TIMEOUT : response stream
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR : APB3 bus
interface apb_cmd_master_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned APB_WIDTH  = 32
);
    logic                  CMD_VALID;
    logic                  CMD_READY;
    logic                  CMD_WRITE;
    logic [ADDR_WIDTH-1:0] CMD_ADDR;
    logic [APB_WIDTH-1:0]  CMD_WDATA;

    logic                  RSP_VALID;
    logic                  RSP_READY;
    logic [APB_WIDTH-1:0]  RSP_RDATA;
    logic                  RSP_ERR;
    logic                  RSP_TIMEOUT;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [APB_WIDTH-1:0]  PWDATA;
    logic [APB_WIDTH-1:0]  PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA,
        output CMD_READY,
        output RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
        input  RSP_READY,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA,
        input  CMD_READY,
        input  RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
        output RSP_READY,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 initiator: converts a valid/ready command stream into
// APB SETUP/ACCESS transfers and returns read data/status on a valid/ready
// response stream. Every output is a flop; no input reaches an output combinationally.
//   PCLK    : clock, rising edge
//   PRESETN : asynchronous active-low reset; aborts any transfer without a response
//   bus     : apb_cmd_master_if.master (command, response and APB signals)
module apb_cmd_master #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned APB_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             PCLK,
    input  logic             PRESETN,
    apb_cmd_master_if.master bus
);
    // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit when timeout is off.
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_WIDTH-1:0]  pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [APB_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic cmd_fire_c;
    logic timeout_hit_c;

    // A command is taken only once CMD_READY is actually visible to the source.
    assign cmd_fire_c    = (state_q == S_IDLE) && cmd_ready_q && bus.CMD_VALID;
    // cnt_q counts completed wait cycles, so this ACCESS cycle is number cnt_q+1.
    assign timeout_hit_c = TO_EN && (cnt_q == CNT_W'(TO_LAST));

    // State register.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; PREADY wins over a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cmd_fire_c) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (bus.PREADY || timeout_hit_c) state_d = S_RESP;
            S_RESP:   if (bus.RSP_READY) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; handshake flags follow the state being entered.
    always_comb begin
        cmd_ready_d   = (state_d == S_IDLE);
        psel_d        = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d     = (state_d == S_ACCESS);
        rsp_valid_d   = (state_d == S_RESP);
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire_c) begin
                    paddr_d  = bus.CMD_ADDR;
                    pwrite_d = bus.CMD_WRITE;
                    pwdata_d = bus.CMD_WRITE ? bus.CMD_WDATA : '0;
                end
            end
            S_SETUP: begin
                cnt_d = '0;
            end
            S_ACCESS: begin
                if (bus.PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d     = bus.PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit_c) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b1;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.CMD_READY   = cmd_ready_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.RSP_VALID   = rsp_valid_q;
    assign bus.RSP_RDATA   = rsp_rdata_q;
    assign bus.RSP_ERR     = rsp_err_q;
    assign bus.RSP_TIMEOUT = rsp_timeout_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: timeline model of the transfer rules checked every
// cycle, a programmable APB slave, and directed scenarios with literal expectations.
module tb_apb_cmd_master;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tb_cyc = 0;
    int   n_chk  = 0;
    int   n_err  = 0;

    apb_cmd_master_if #(.ADDR_WIDTH(AW), .APB_WIDTH(DW)) bus ();

    apb_cmd_master #(
        .ADDR_WIDTH(AW), .APB_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(clk), .PRESETN(rst_n), .bus(bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Programmable slave: PREADY on ACCESS cycle sl_wait+1 unless stuck.
    bit          sl_stuck = 1'b0;
    bit          sl_err   = 1'b0;
    int          sl_wait  = 0;
    logic [31:0] sl_rdata = 32'h0;
    int          sl_n     = 0;
    always @(negedge clk) begin
        if (bus.PSEL && bus.PENABLE) sl_n++;
        else sl_n = 0;
        bus.PREADY  = !sl_stuck && (sl_n == sl_wait + 1);
        bus.PRDATA  = sl_rdata;
        bus.PSLVERR = sl_err;
    end

    // Model: transfer timeline measured in edges from the accepting edge m_acc.
    bit          m_busy = 1'b0;
    bit          m_pend = 1'b0;
    int          m_cyc  = 0;
    int          m_acc  = 0;
    int          m_n    = 0;
    logic        m_write = 1'b0;
    logic        e_ready = 1'b0, e_psel = 1'b0, e_pen = 1'b0, e_rvalid = 1'b0;
    logic        e_err = 1'b0, e_to = 1'b0, e_pwrite = 1'b0;
    logic [AW-1:0] e_paddr  = '0;
    logic [DW-1:0] e_pwdata = '0;
    logic [DW-1:0] e_rdata  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_pend = 1'b0; m_cyc = 0;
            e_ready = 1'b0; e_psel = 1'b0; e_pen = 1'b0; e_rvalid = 1'b0;
            e_err = 1'b0; e_to = 1'b0; e_pwrite = 1'b0;
            e_paddr = '0; e_pwdata = '0; e_rdata = '0;
        end else begin
            m_cyc++;
            if (m_busy) begin
                m_n = m_cyc - m_acc - 1;   // 0: setup edge, k>0: end of ACCESS cycle k
                if (m_n == 0) begin
                    e_pen = 1'b1;
                end else if (bus.PREADY || (TO != 0 && m_n == int'(TO))) begin
                    m_busy = 1'b0; m_pend = 1'b1;
                    e_psel = 1'b0; e_pen = 1'b0; e_rvalid = 1'b1;
                    e_to    = !bus.PREADY;
                    e_err   = bus.PREADY && bus.PSLVERR;
                    e_rdata = (bus.PREADY && !m_write) ? bus.PRDATA : 32'h0;
                end
            end else if (m_pend) begin
                if (bus.RSP_READY) begin
                    m_pend = 1'b0; e_rvalid = 1'b0; e_ready = 1'b1;
                end
            end else if (e_ready && bus.CMD_VALID) begin
                m_busy = 1'b1; m_acc = m_cyc; m_write = bus.CMD_WRITE;
                e_ready = 1'b0; e_psel = 1'b1;
                e_paddr = bus.CMD_ADDR; e_pwrite = bus.CMD_WRITE;
                e_pwdata = bus.CMD_WRITE ? bus.CMD_WDATA : 32'h0;
            end else begin
                e_ready = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cmd_ready", 32'(bus.CMD_READY), 32'(e_ready));
        chk("psel",      32'(bus.PSEL),      32'(e_psel));
        chk("penable",   32'(bus.PENABLE),   32'(e_pen));
        chk("rsp_valid", 32'(bus.RSP_VALID), 32'(e_rvalid));
        if (e_psel) begin
            chk("paddr",  32'(bus.PADDR),  32'(e_paddr));
            chk("pwrite", 32'(bus.PWRITE), 32'(e_pwrite));
            chk("pwdata", 32'(bus.PWDATA), 32'(e_pwdata));
        end
        if (e_rvalid) begin
            chk("rsp_rdata",   32'(bus.RSP_RDATA),   32'(e_rdata));
            chk("rsp_err",     32'(bus.RSP_ERR),     32'(e_err));
            chk("rsp_timeout", 32'(bus.RSP_TIMEOUT), 32'(e_to));
        end
    end

    // Present a command from a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit w, input logic [7:0] a, input logic [31:0] d);
        int k;
        k = 0;
        bus.CMD_VALID = 1'b1; bus.CMD_WRITE = w; bus.CMD_ADDR = a; bus.CMD_WDATA = d;
        while (!bus.CMD_READY && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_accept_bound", 32'(k < 20), 32'd1);
        @(negedge clk);
        bus.CMD_VALID = 1'b0;
    endtask

    // lat: cycle offset (from the accepting edge) at which RSP_VALID is first seen.
    task automatic wait_rsp(output int pen_n, output int lat);
        int k;
        pen_n = 0; lat = 1; k = 0;
        while (!bus.RSP_VALID && k < 40) begin
            if (bus.PENABLE) pen_n++;
            @(negedge clk);
            lat++; k++;
        end
        chk("rsp_wait_bound", 32'(k < 40), 32'd1);
    endtask

    task automatic xfer(input bit w, input logic [7:0] a, input logic [31:0] d,
                        output int pen_n, output int lat);
        send(w, a, d);
        wait_rsp(pen_n, lat);
    endtask

    int pen_n, lat;

    initial begin
        bus.CMD_VALID = 1'b0; bus.CMD_WRITE = 1'b0; bus.CMD_ADDR = '0;
        bus.CMD_WDATA = '0;   bus.RSP_READY = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.CMD_READY), 32'd0);
        chk("rst_psel",      32'(bus.PSEL),      32'd0);
        chk("rst_paddr",     32'(bus.PADDR),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.CMD_READY), 32'd1);

        // Zero-wait write
        sl_rdata = 32'hDEADBEEF;
        xfer(1'b1, 8'h01, 32'h000000A5, pen_n, lat);
        chk("t1_lat",     32'(lat),             32'd3);
        chk("t1_pen",     32'(pen_n),           32'd1);
        chk("t1_pwdata",  32'(bus.PWDATA),      32'h000000A5);
        chk("t1_rdata",   32'(bus.RSP_RDATA),   32'h0);
        chk("t1_err",     32'(bus.RSP_ERR),     32'd0);
        chk("t1_timeout", 32'(bus.RSP_TIMEOUT), 32'd0);
        @(negedge clk);

        // Read with three wait states
        sl_wait = 3; sl_rdata = 32'h12345678;
        xfer(1'b0, 8'h00, 32'hFFFFFFFF, pen_n, lat);
        chk("t2_pen",    32'(pen_n),           32'd4);
        chk("t2_lat",    32'(lat),             32'd6);
        chk("t2_rdata",  32'(bus.RSP_RDATA),   32'h12345678);
        chk("t2_err",    32'(bus.RSP_ERR),     32'd0);
        chk("t2_pwdata", 32'(bus.PWDATA),      32'h0);
        @(negedge clk);

        // Slave error on a zero-wait write
        sl_wait = 0; sl_err = 1'b1;
        xfer(1'b1, 8'h03, 32'h0000005A, pen_n, lat);
        chk("t3_lat",     32'(lat),             32'd3);
        chk("t3_err",     32'(bus.RSP_ERR),     32'd1);
        chk("t3_timeout", 32'(bus.RSP_TIMEOUT), 32'd0);
        chk("t3_rdata",   32'(bus.RSP_RDATA),   32'h0);
        @(negedge clk);

        // Timeout with PREADY stuck low (PSLVERR high must be ignored)
        sl_stuck = 1'b1; sl_rdata = 32'hCAFEF00D;
        xfer(1'b0, 8'h02, 32'h0, pen_n, lat);
        chk("t4a_pen",     32'(pen_n),           32'd8);
        chk("t4a_lat",     32'(lat),             32'd10);
        chk("t4a_timeout", 32'(bus.RSP_TIMEOUT), 32'd1);
        chk("t4a_rdata",   32'(bus.RSP_RDATA),   32'h0);
        chk("t4a_err",     32'(bus.RSP_ERR),     32'd0);
        @(negedge clk);

        // PREADY exactly in ACCESS cycle 8 completes normally
        sl_stuck = 1'b0; sl_err = 1'b0; sl_wait = 7;
        xfer(1'b0, 8'h02, 32'h0, pen_n, lat);
        chk("t4b_pen",     32'(pen_n),           32'd8);
        chk("t4b_lat",     32'(lat),             32'd10);
        chk("t4b_timeout", 32'(bus.RSP_TIMEOUT), 32'd0);
        chk("t4b_rdata",   32'(bus.RSP_RDATA),   32'hCAFEF00D);
        @(negedge clk);

        // Response back-pressure with the next command already waiting
        bus.RSP_READY = 1'b0; sl_wait = 0; sl_rdata = 32'h0BADF00D;
        xfer(1'b1, 8'h04, 32'h00000011, pen_n, lat);
        bus.CMD_VALID = 1'b1; bus.CMD_WRITE = 1'b0; bus.CMD_ADDR = 8'h05; bus.CMD_WDATA = 32'h0;
        repeat (5) begin
            chk("bp_rvalid",  32'(bus.RSP_VALID),   32'd1);
            chk("bp_ready",   32'(bus.CMD_READY),   32'd0);
            chk("bp_psel",    32'(bus.PSEL),        32'd0);
            chk("bp_rdata",   32'(bus.RSP_RDATA),   32'h0);
            chk("bp_err",     32'(bus.RSP_ERR),     32'd0);
            chk("bp_timeout", 32'(bus.RSP_TIMEOUT), 32'd0);
            @(negedge clk);
        end
        bus.RSP_READY = 1'b1;
        @(negedge clk);
        chk("bp_gap_psel",   32'(bus.PSEL),      32'd0);
        chk("bp_gap_ready",  32'(bus.CMD_READY), 32'd1);
        chk("bp_gap_rvalid", 32'(bus.RSP_VALID), 32'd0);
        @(negedge clk);
        bus.CMD_VALID = 1'b0;
        chk("bp_next_psel",  32'(bus.PSEL),  32'd1);
        chk("bp_next_paddr", 32'(bus.PADDR), 32'h05);
        wait_rsp(pen_n, lat);
        chk("bp_next_lat",   32'(lat),           32'd3);
        chk("bp_next_rdata", 32'(bus.RSP_RDATA), 32'h0BADF00D);
        @(negedge clk);

        // Asynchronous reset in the middle of ACCESS
        sl_stuck = 1'b1;
        send(1'b0, 8'h06, 32'h0);
        @(negedge clk);
        chk("t6_in_access", 32'(bus.PENABLE), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_psel",      32'(bus.PSEL),      32'd0);
        chk("t6_penable",   32'(bus.PENABLE),   32'd0);
        chk("t6_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        chk("t6_cmd_ready", 32'(bus.CMD_READY), 32'd0);
        sl_stuck = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_after", 32'(bus.CMD_READY), 32'd1);
        repeat (6) begin
            chk("t6_no_stale", 32'(bus.RSP_VALID), 32'd0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of sequence, want completion by t=%0t", $time);
        $fatal(1, "bench watchdog expired");
    end
endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Single-outstanding APB3 initiator. Turns a valid/ready command stream (address, write flag, write data) into APB SETUP/ACCESS transfers, then returns read data and status on a valid/ready response stream.
- Sits between the SoC control logic (or RISC-V peripheral bridge) and APB slaves such as the CoreGPIO register block.
- Takes over, in synthesizable RTL, the role the APB master BFM plays in simulation.

Parameters:
- ADDR_WIDTH, 8, width of CMD_ADDR/PADDR.
- APB_WIDTH, 32, data width of CMD_WDATA/PWDATA/PRDATA/RSP_RDATA; legal values 8, 16, 32.
- TIMEOUT_CYCLES, 255, max ACCESS cycles waiting for PREADY before abort; 0 disables timeout.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETN  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  master can accept a command.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  ADDR_WIDTH  target address.
- CMD_WDATA  in  APB_WIDTH  write data; ignored for reads.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  consumer accepts the response.
- RSP_RDATA  out  APB_WIDTH  read data; 0 for writes and timeouts.
- RSP_ERR  out  1  slave returned PSLVERR=1.
- RSP_TIMEOUT  out  1  transfer aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  APB_WIDTH  APB write data.
- PRDATA  in  APB_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset (PRESETN=0, asynchronous):
  - State goes to IDLE.
  - All outputs 0: CMD_READY, RSP_*, PSEL, PENABLE, PWRITE, PADDR, PWDATA.
  - Wait counter cleared.
  - A reset mid-transfer drops PSEL/PENABLE immediately and discards the transfer; no response is produced.
- Registers: all outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - CMD_READY=1, PSEL=0, PENABLE=0.
  - On a clock edge with CMD_VALID=1: register CMD_ADDR→PADDR, CMD_WRITE→PWRITE, CMD_WDATA→PWDATA (PWDATA=0 for reads); go to SETUP.
  - PADDR/PWRITE/PWDATA otherwise hold their last values.
- SETUP:
  - PSEL=1, PENABLE=0, CMD_READY=0.
  - Always exactly one cycle, then ACCESS; clear wait counter.
- ACCESS:
  - PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA stable.
  - At each edge with PREADY=1:
    - RSP_RDATA = read ? PRDATA : 0.
    - RSP_ERR = PSLVERR, RSP_TIMEOUT=0.
    - Drop PSEL/PENABLE; go to RESP.
  - At each edge with PREADY=0: increment the counter.
  - If TIMEOUT_CYCLES≠0 and this is ACCESS cycle number TIMEOUT_CYCLES:
    - RSP_RDATA=0, RSP_ERR=0, RSP_TIMEOUT=1.
    - Drop PSEL/PENABLE; go to RESP.
  - PREADY=1 in the timeout cycle takes priority: normal completion, no timeout.
  - Counter width is clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- RESP:
  - RSP_VALID=1, CMD_READY=0, PSEL=0.
  - RSP_RDATA/RSP_ERR/RSP_TIMEOUT held stable while RSP_VALID=1 and RSP_READY=0.
  - On an edge with RSP_READY=1: RSP_VALID→0, go to IDLE.
  - A command waiting on CMD_VALID is accepted at the next edge, i.e. one IDLE cycle between responses.
- Latency:
  - Command accepted at edge t: PSEL=1 from t+1, PENABLE=1 from t+2.
  - With zero wait states, RSP_VALID=1 from t+3.
  - Each wait state adds one cycle.
  - Maximum throughput is 1 transfer per 4 cycles with RSP_READY tied high.
- Protocol:
  - PENABLE is never 1 while PSEL=0.
  - PSEL is never held across two back-to-back transfers.
  - PRDATA and PSLVERR are sampled only in ACCESS with PREADY=1.

Test Plan:
1. Zero-wait write: CMD_WRITE=1, CMD_ADDR=0x01, CMD_WDATA=0x000000A5, PREADY=1, accepted at t → PSEL rises t+1, PENABLE rises t+2, PWDATA=0xA5 throughout, RSP_VALID at t+3, RSP_ERR=0, RSP_TIMEOUT=0, RSP_RDATA=0.
2. Read with 3 wait states: CMD_ADDR=0x00, slave returns PREADY=1 on the 4th ACCESS cycle with PRDATA=0x12345678 → PENABLE high 4 cycles, RSP_RDATA=0x12345678, RSP_ERR=0.
3. Slave error: write to 0x03 with PREADY=1, PSLVERR=1 → RSP_ERR=1, RSP_TIMEOUT=0, transfer otherwise identical to scenario 1.
4. Timeout: TIMEOUT_CYCLES=8, PREADY stuck at 0 → PSEL/PENABLE drop after the 8th ACCESS cycle, RSP_TIMEOUT=1, RSP_RDATA=0; repeat with PREADY=1 exactly in cycle 8 → normal completion, RSP_TIMEOUT=0.
5. Back-pressure: RSP_READY low for 5 cycles with the next CMD_VALID already high → RSP fields stable, CMD_READY=0, no PSEL; new command accepted one cycle after the response handshake, PSEL low ≥1 cycle between transfers.
6. Reset mid-ACCESS: PRESETN=0 asynchronously → PSEL, PENABLE, RSP_VALID, CMD_READY all 0 immediately; after release, CMD_READY=1 on the first edge and no stale response appears.
